// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_arb_pkg : state encodings and sizing helpers for the UART arbiter
// Rev 1.0
// ============================================================================
package uart_tx_arb_pkg;

  localparam int UART_CLK_HZ = 12_000_000;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_START   = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_HI = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_LO = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP     = 3'd4;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin search starting at PTR, wrapping mod N
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  REQ,
  input  logic [PW-1:0] PTR,
  output logic [PW-1:0] GNT_IDX,
  output logic          GNT_VALID
);

  always_comb begin : p_pick
    int          cand_i;
    logic [PW-1:0] cand;
    cand_i    = 0;
    cand      = '0;
    GNT_IDX   = '0;
    GNT_VALID = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_i = int'(PTR) + i;
      if (cand_i >= N) cand_i = cand_i - N;
      cand = PW'(cand_i);
      if (!GNT_VALID && REQ[cand]) begin
        GNT_VALID = 1'b1;
        GNT_IDX   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// uart_tx_arb : round-robin scheduler sharing one uart_tx among N producers
// Rev 1.0
// ============================================================================
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N             = 4,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   REQ,
  input  logic [8*N-1:0] REQ_DATA,
  output logic [N-1:0]   ACK,
  output logic           TX_START,
  output logic [7:0]     TX_DATA,
  input  logic           TX_BUSY,
  output logic           ERR,
  output logic           ACTIVE
);

  localparam int PW = $clog2(N);
  localparam int WW = cnt_width(START_TIMEOUT);
  localparam int GW = cnt_width(GAP_CYCLES);

  localparam logic [WW-1:0] WD_LAST  = WW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [PW-1:0]   ptr;
  logic [WW-1:0]   wd_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic            grant;
  logic            wd_expire;

  logic [N-1:0]    ack_d;
  logic            start_d;
  logic [7:0]      data_d;
  logic            err_d;
  logic            active_d;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .REQ       (REQ),
    .PTR       (ptr),
    .GNT_IDX   (gnt_idx),
    .GNT_VALID (gnt_valid)
  );

  // A frame already on the line (ours or foreign) blocks new grants.
  assign grant     = (state == ST_IDLE) && gnt_valid && !TX_BUSY;
  assign wd_expire = (state == ST_WAIT_HI) && !TX_BUSY && (wd_cnt == WD_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr     <= '0;
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (grant) ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
      wd_cnt  <= (state == ST_WAIT_HI) ? wd_cnt + 1'b1 : '0;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant) state_nxt = ST_START;
      ST_START:   state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (TX_BUSY)        state_nxt = ST_WAIT_LO;
        else if (wd_expire) state_nxt = ST_IDLE;
      end
      ST_WAIT_LO: begin
        if (!TX_BUSY) begin
          if (GAP_CYCLES > 0) state_nxt = ST_GAP;
          else                state_nxt = ST_IDLE;
        end
      end
      ST_GAP:     if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered below.
  always_comb begin
    ack_d    = '0;
    start_d  = 1'b0;
    data_d   = TX_DATA;
    err_d    = wd_expire;
    active_d = (state_nxt != ST_IDLE);
    if (grant) begin
      ack_d[gnt_idx] = 1'b1;
      start_d        = 1'b1;
      data_d         = REQ_DATA[{gnt_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ACK      <= '0;
      TX_START <= 1'b0;
      TX_DATA  <= 8'h00;
      ERR      <= 1'b0;
      ACTIVE   <= 1'b0;
    end else begin
      ACK      <= ack_d;
      TX_START <= start_d;
      TX_DATA  <= data_d;
      ERR      <= err_d;
      ACTIVE   <= active_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one `uart_tx` instance between `N` byte producers, such as a debug dumper, a status reporter and a character echo. It accepts one byte per grant, drives the transmitter's `START`/`DATA` inputs and tracks its `BUSY` output. It then enforces an optional inter-byte gap and a start watchdog. It sits between the producers and `uart_tx` in each board `top`.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 0: idle clocks inserted after `BUSY` falls before the next grant.
- `START_TIMEOUT`, 15: clocks allowed for `BUSY` to rise after `START`.

Ports:
- `CLK` input 1: system clock, 12 MHz on the board.
- `RST_N` input 1: reset, asynchronous and active-low.
- `REQ` input N: `REQ[i]=1` means requester i has a byte pending.
- `REQ_DATA` input 8*N: byte of requester i at bits `[8*i+7:8*i]`.
- `ACK` output N: one-clock pulse; the byte of requester i is taken.
- `TX_START` output 1: one-clock start pulse to `uart_tx` `START`.
- `TX_DATA` output 8: registered byte to `uart_tx` `DATA`, held until the next grant.
- `TX_BUSY` input 1: from `uart_tx` `BUSY`; high while a frame is on the line.
- `ERR` output 1: one-clock pulse when `BUSY` never rose within `START_TIMEOUT`.
- `ACTIVE` output 1: high in every state except IDLE, intended for an LED.

## Operation
- Reset values: `ACK`=0, `TX_START`=0, `TX_DATA`=8'h00, `ERR`=0, `ACTIVE`=0. State is IDLE and the priority pointer is 0.
- States:
  - IDLE: if `|REQ`, pick a winner g, then go to START. Otherwise stay in IDLE.
  - START: the one cycle in which `TX_START`=1 and `ACK[g]`=1. Always go to WAIT_HI.
  - WAIT_HI: when `TX_BUSY`=1, go to WAIT_LO. When the watchdog reaches `START_TIMEOUT` with `BUSY` still low, pulse `ERR` and go to IDLE.
  - WAIT_LO: when `TX_BUSY`=0, go to GAP if `GAP_CYCLES`>0, otherwise go to IDLE.
  - GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- Arbitration is round-robin. The search starts at the pointer and runs upward with wrap modulo N. After granting g, the pointer becomes (g+1) mod N. A requester that is not asserting `REQ` is skipped, with no penalty.
- Requester rules:
  - Hold `REQ` and `REQ_DATA` stable until `ACK` is seen.
  - `REQ_DATA` is sampled into `TX_DATA` on the IDLE-to-START edge.
  - A `REQ` still high in the cycle after `ACK` counts as a new byte.
- `TX_BUSY` already high in IDLE, for example from a foreign start: no grant is issued until it is low.
- On timeout the byte counts as consumed, since `ACK` was already given. The pointer has still advanced.
- Reset mid-frame: all outputs return to their reset values immediately. The frame in flight inside `uart_tx` is not aborted by this block.
- Watchdog counter width is `$clog2(START_TIMEOUT+1)`. The gap counter width is `$clog2(GAP_CYCLES+1)`, minimum 1. Both clear on entry to their state.

## Timing
- Grant latency: `REQ` seen in IDLE at edge t gives `TX_START`/`ACK` high in cycle t+1 and low in cycle t+2.
- `TX_DATA` is valid at the same edge as `TX_START` and stays valid through WAIT_LO.
- Back-to-back bytes are separated by: `BUSY` fall, then `GAP_CYCLES` clocks, then 1 IDLE clock, then `START`.
- The minimum request-to-request cycle, excluding the frame itself, is 3 + `GAP_CYCLES` clocks.
- All outputs are registered. There is no combinational path from `REQ` or `TX_BUSY` to any output.

## Structure
- Shared package or include `uart_pkg.vh` holds:
  - the state encodings ST_IDLE, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_GAP;
  - a `UART_CLK_HZ` default of 12_000_000, shared with `uart_tx`.
- Sub-module `rr_pick`: purely combinational. It takes `N`, `REQ`, and pointer `PTR`, and returns `GNT_IDX` and `GNT_VALID`. It is instantiated once.
- `uart_tx` is not instantiated inside this block; `top` wires the two together.

## Test plan
- Single requester, N=4, `REQ[2]`=1, data 8'h41, real `uart_tx` at 9600 baud: one `TX_START`. `ACK`=4'b0100 in the same cycle. The line carries 'A', then the block returns to IDLE with `ACTIVE`=0.
- All four requesting with data 8'h30..8'h33 held after each `ACK`: grants come in order 0,1,2,3,0,… and the line carries "0123" repeating.
- Pointer wrap: pointer=3 with `REQ`=4'b1001: requester 3 is granted first, then requester 0.
- `GAP_CYCLES`=5 with a behavioural `BUSY` model: exactly 5+1 clocks pass from `BUSY` falling to the next `TX_START`.
- Tie-low `TX_BUSY` with `START_TIMEOUT`=15: `ERR` pulses 16 clocks after `TX_START`, the state is back in IDLE, and the next requester is granted.
- Assert `RST_N`=0 during WAIT_LO: all outputs return to their reset values asynchronously. After release the pointer is 0 and requester 0 wins.
